// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART 8N1 receiver. Oversamples the asynchronous rx line on the
//            system clock, qualifies the start bit at mid-bit, shifts in
//            8 data bits LSB first and checks the stop bit. Pairs with
//            uart_tx at the far end of the link and uses the same 3-bit
//            baud selector and bit timing (bit period = div+1 clocks).
//
// Ports    : clk        system clock
//            rst        asynchronous active-high reset
//            rx         serial line, idle high, asynchronous to clk
//            bps[2:0]   baud select (000..100; 101..111 fall back to 000)
//            data[7:0]  last correctly framed byte
//            valid      one-cycle pulse, data updated this cycle
//            frame_err  one-cycle pulse, stop bit sampled low
//            busy       high whenever the receiver is not idle
//
// Options  : UART_RX_MAJORITY_EN - when defined, every bit decision is the
//            2-of-3 majority of the synchronised line around the bit centre,
//            taken one cycle after the nominal sample point.
//
// Revision : 1.0 - initial release
// ============================================================================

module uart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int BPS0_DIV    = 5208,
    parameter int BPS1_DIV    = 2603,
    parameter int BPS2_DIV    = 1301,
    parameter int BPS3_DIV    = 867,
    parameter int BPS4_DIV    = 433
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [2:0] bps,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // A synchroniser shorter than two flops gives no metastability margin.
    localparam int c_SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Counter is sized for the slowest configured rate.
    localparam int c_MAX_01  = (BPS0_DIV > BPS1_DIV) ? BPS0_DIV : BPS1_DIV;
    localparam int c_MAX_23  = (BPS2_DIV > BPS3_DIV) ? BPS2_DIV : BPS3_DIV;
    localparam int c_MAX_03  = (c_MAX_01 > c_MAX_23) ? c_MAX_01 : c_MAX_23;
    localparam int c_MAX_DIV = (c_MAX_03 > BPS4_DIV) ? c_MAX_03 : BPS4_DIV;
    localparam int c_CNT_W   = (c_MAX_DIV < 2) ? 1 : $clog2(c_MAX_DIV + 1);

    localparam logic [c_CNT_W-1:0] c_DIV0    = c_CNT_W'(BPS0_DIV);
    localparam logic [c_CNT_W-1:0] c_DIV1    = c_CNT_W'(BPS1_DIV);
    localparam logic [c_CNT_W-1:0] c_DIV2    = c_CNT_W'(BPS2_DIV);
    localparam logic [c_CNT_W-1:0] c_DIV3    = c_CNT_W'(BPS3_DIV);
    localparam logic [c_CNT_W-1:0] c_DIV4    = c_CNT_W'(BPS4_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // State encoding
    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_STOP      = 3'd3;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd4;

    // ------------------------------------------------------------------------
    // Input synchroniser. Preset to 1 so the line looks idle out of reset and
    // the first edge after reset cannot be mistaken for a start bit.
    // ------------------------------------------------------------------------
    logic [c_SYNC_N-1:0] r_sync;
    logic                w_rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[c_SYNC_N-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[c_SYNC_N-1];

    // ------------------------------------------------------------------------
    // Bit decision path.
    //   w_line      : line level seen by the edge detector / break wait
    //   w_line_prev : w_line one cycle earlier
    //   w_bit       : value used at each sample point
    // ------------------------------------------------------------------------
    logic w_line;
    logic w_line_prev;
    logic w_bit;

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] = rx_s one cycle ago, r_hist[1] = two cycles ago. Running the
    // whole FSM on the delayed line shifts every sample point by one cycle,
    // so the vote covers the nominal centre sample and both neighbours.
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_line      = r_hist[0];
    assign w_line_prev = r_hist[1];
    assign w_bit       = (r_hist[1] & r_hist[0]) |
                         (r_hist[1] & w_rx_s)    |
                         (r_hist[0] & w_rx_s);
`else
    logic r_rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= w_rx_s;
        end
    end

    assign w_line      = w_rx_s;
    assign w_line_prev = r_rx_prev;
    assign w_bit       = w_rx_s;
`endif

    logic w_start_edge;
    assign w_start_edge = w_line_prev & ~w_line;

    // ------------------------------------------------------------------------
    // Baud selector decode (unused codes fall back to the slowest rate)
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] w_div_sel;

    always_comb begin
        w_div_sel = c_DIV0;
        case (bps)
            3'b000:  w_div_sel = c_DIV0;
            3'b001:  w_div_sel = c_DIV1;
            3'b010:  w_div_sel = c_DIV2;
            3'b011:  w_div_sel = c_DIV3;
            3'b100:  w_div_sel = c_DIV4;
            default: w_div_sel = c_DIV0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Receiver state and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_div;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_ferr;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_div_nxt;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         w_shift_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_valid_nxt;
    logic               w_ferr_nxt;
    logic [c_CNT_W-1:0] w_half;

    assign w_half = r_div >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_div   <= c_DIV0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_div_nxt   = r_div;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start_edge) begin
                    // Rate is frozen for the whole frame.
                    w_div_nxt   = w_div_sel;
                    w_state_nxt = c_ST_START;
                end
            end

            c_ST_START: begin
                if (r_cnt == w_half) begin
                    w_cnt_nxt = '0;
                    if (!w_bit) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = c_ST_DATA;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end

            c_ST_DATA: begin
                // Counting from the start-bit centre, cnt==div lands on the
                // centre of each following bit.
                if (r_cnt == r_div) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_bit, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end

            c_ST_STOP: begin
                if (r_cnt == r_div) begin
                    w_cnt_nxt = '0;
                    if (w_bit) begin
                        // Back to idle at the stop centre so a start bit
                        // right behind this stop bit is still seen.
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = c_ST_WAIT_HIGH;
                    end
                end
            end

            c_ST_WAIT_HIGH: begin
                // Absorb a break: one error report, then wait for idle.
                w_cnt_nxt = '0;
                if (w_line) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. A driver serialises frames
//            bit by bit, a reference model predicts each frame's outcome
//            (byte or framing error) into a queue, and a monitor pops the
//            queue whenever the receiver pulses valid or frame_err.
// Revision : 1.0 - initial release
// ============================================================================

module tb_uart_rx;

    // Reduced divisors for the slower rates keep run time short; the
    // 115200 setting keeps its real value so the latency figure is genuine.
    localparam int D0 = 200;
    localparam int D1 = 150;
    localparam int D2 = 100;
    localparam int D3 = 65;
    localparam int D4 = 433;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [2:0] bps = 3'b100;
    wire  [7:0] data;
    wire        valid;
    wire        frame_err;
    wire        busy;

    uart_rx #(
        .SYNC_STAGES (2),
        .BPS0_DIV    (D0),
        .BPS1_DIV    (D1),
        .BPS2_DIV    (D2),
        .BPS3_DIV    (D3),
        .BPS4_DIV    (D4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .bps       (bps),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] last_good = 8'h00;
    int         last_valid_cyc = 0;

    // Reference model: bit period for a baud code.
    function automatic int div_of(input logic [2:0] code);
        case (code)
            3'd0:    return D0;
            3'd1:    return D1;
            3'd2:    return D2;
            3'd3:    return D3;
            3'd4:    return D4;
            default: return D0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void expect_byte(input logic [7:0] b);
        ev_t e;
        e.is_err = 1'b0;
        e.data   = b;
        exp_q.push_back(e);
        last_good = b;
    endfunction

    function automatic void expect_ferr();
        ev_t e;
        e.is_err = 1'b1;
        e.data   = last_good;   // data must hold its previous value
        exp_q.push_back(e);
    endfunction

    // Monitor: pops one expectation per output pulse.
    always @(negedge clk) begin
        if (!rst && (valid || frame_err)) begin
            ev_t e;
            chk("pulse_exclusive", {31'b0, valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("event_expected", exp_q.size(), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {31'b0, frame_err}, {31'b0, e.is_err});
                chk("event_data", {24'b0, data}, {24'b0, e.data});
            end
            if (valid) last_valid_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame, called right after a negedge. p = bit period in clocks.
    // stop_low   : number of bit times the stop bit is held low (0 = good stop)
    // spike      : invert rx for one clock at the centre of each data bit
    // abort_bit  : frame bit index (0 = start) at whose middle rst is pulsed
    // scramble   : change bps randomly once the start bit has been sent
    task automatic send_frame(input logic [7:0] b, input int p, input int stop_low,
                              input bit spike, input int abort_bit, input bit scramble);
        logic [9:0] fr;
        logic       v;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < p; c++) begin
                if (k == abort_bit && c == p / 2) begin
                    rst = 1'b1;
                    #1;
                    chk("abort_data",      {24'b0, data},      32'd0);
                    chk("abort_valid",     {31'b0, valid},     32'd0);
                    chk("abort_frame_err", {31'b0, frame_err}, 32'd0);
                    chk("abort_busy",      {31'b0, busy},      32'd0);
                    rx = 1'b1;
                    exp_q.delete();
                    last_good = 8'h00;
                    @(negedge clk);
                    repeat (4) @(negedge clk);
                    rst = 1'b0;
                    repeat (5) @(negedge clk);
                    return;
                end
                v = fr[k];
                if (k == 9 && stop_low > 0) v = 1'b0;
                // Receiver samples bit centre at offset half+1 of each bit.
                if (spike && k >= 1 && k <= 8 && c == ((p - 1) / 2) + 1) v = ~v;
                rx = v;
                @(negedge clk);
            end
            if (k == 0 && scramble) bps = 3'($urandom_range(0, 7));
        end
        if (stop_low > 1) begin
            rx = 1'b0;
            repeat ((stop_low - 1) * p) @(negedge clk);
        end
    endtask

    initial begin
        int         t0;
        int         lat;
        int         lat_req;
        logic [2:0] code;
        logic [7:0] b;

        rst = 1'b1;
        rx  = 1'b1;
        bps = 3'b100;
        repeat (3) @(negedge clk);
        chk("reset_data",      {24'b0, data},      32'd0);
        chk("reset_valid",     {31'b0, valid},     32'd0);
        chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
        chk("reset_busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;
        idle(5);

        // 0x55 at 115200 with latency measurement
        bps = 3'b100;
        t0  = cyc;
        expect_byte(8'h55);
        send_frame(8'h55, D4 + 1, 0, 1'b0, -1, 1'b0);
        idle(5);
        lat     = last_valid_cyc - t0;
        lat_req = 3 + (D4 >> 1) + 9 * (D4 + 1) + MAJ;
        chk("latency", (lat >= lat_req - 1 && lat <= lat_req + 1) ? lat_req : lat, lat_req);
        chk("q_empty_55", exp_q.size(), 32'd0);

        // Back-to-back frames at code 000
        bps = 3'b000;
        expect_byte(8'hA3);
        send_frame(8'hA3, D0 + 1, 0, 1'b0, -1, 1'b0);
        expect_byte(8'h00);
        send_frame(8'h00, D0 + 1, 0, 1'b0, -1, 1'b0);
        expect_byte(8'hFF);
        send_frame(8'hFF, D0 + 1, 0, 1'b0, -1, 1'b0);
        idle(5);
        chk("q_empty_b2b", exp_q.size(), 32'd0);

        // Start-bit glitch of 100 clocks at 115200
        bps = 3'b100;
        rx  = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_busy_mid", {31'b0, busy}, 32'd1);
        repeat (150) @(negedge clk);
        chk("glitch_busy_end", {31'b0, busy}, 32'd0);

        // Framing error with a 20-bit break, then recovery
        bps = 3'b001;
        expect_ferr();
        send_frame(8'h3C, D1 + 1, 20, 1'b0, -1, 1'b0);
        chk("break_busy", {31'b0, busy}, 32'd1);
        idle(10);
        chk("break_release_busy", {31'b0, busy}, 32'd0);
        chk("q_empty_ferr", exp_q.size(), 32'd0);
        expect_byte(8'h81);
        send_frame(8'h81, D1 + 1, 0, 1'b0, -1, 1'b0);
        idle(5);
        chk("q_empty_81", exp_q.size(), 32'd0);

        // Reset in the middle of data bit 4, then a clean frame
        bps = 3'b010;
        send_frame(8'h5A, D2 + 1, 0, 1'b0, 5, 1'b0);
        chk("q_empty_abort", exp_q.size(), 32'd0);
        expect_byte(8'h7E);
        send_frame(8'h7E, D2 + 1, 0, 1'b0, -1, 1'b0);
        idle(5);
        chk("q_empty_7e", exp_q.size(), 32'd0);

        // One-clock spike on every data-bit centre: majority voting rejects it,
        // a single sample reads every bit inverted.
        bps = 3'b100;
        expect_byte((MAJ != 0) ? 8'h96 : 8'h69);
        send_frame(8'h96, D4 + 1, 0, 1'b1, -1, 1'b0);
        idle(5);
        chk("q_empty_spike", exp_q.size(), 32'd0);

        // Random bytes at random rates, bps disturbed mid-frame
        for (int n = 0; n < 6; n++) begin
            code = 3'($urandom_range(0, 7));
            b    = 8'($urandom);
            bps  = code;
            expect_byte(b);
            send_frame(b, div_of(code) + 1, 0, 1'b0, -1, 1'b1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(10);
        chk("q_empty_random", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART 8N1 receiver. Counterpart to the team's uart_tx at the far end of the serial link. Oversamples the asynchronous rx line on the 50 MHz system clock, qualifies the start bit at mid-bit, and shifts in 8 data bits LSB first. Presents each byte with a one-cycle valid strobe. Uses the same 3-bit baud selector encoding as the transmitter.

Parameters:
SYNC_STAGES, 2, number of flops in the rx input synchronizer (minimum 2)
BPS0_DIV, 5208, bit-period divisor for bps=000 (9600 @ 50 MHz)
BPS1_DIV, 2603, divisor for bps=001 (19200)
BPS2_DIV, 1301, divisor for bps=010 (38400)
BPS3_DIV, 867, divisor for bps=011 (57600)
BPS4_DIV, 433, divisor for bps=100 (115200)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset, asynchronous, active-high
rx  input  1  serial line, idle high, asynchronous to clk
bps  input  3  baud select, same encoding as uart_tx
data  output  8  last correctly framed byte
valid  output  1  one-cycle pulse: data updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): data=8'h00, valid=0, frame_err=0, busy=0. State=IDLE, counter=0, bit index=0. Synchronizer flops preset to 1 so the line reads idle and no false start occurs.
- rx passes through SYNC_STAGES flops; rx_s is the last stage. A start edge is rx_s low while the previous rx_s was high.
- Bit period is div+1 clk cycles: the counter runs 0..div, then restarts. This matches uart_tx timing. Half = div>>1.
- div is latched from bps on start-edge detection. bps changes mid-frame have no effect. Codes 101/110/111 select BPS0_DIV.
- States:
  IDLE: start edge -> START, cnt=0.
  START: at cnt==half, sample rx_s. If 0 -> DATA, cnt=0, idx=0. If 1 -> IDLE with no flags (glitch rejection).
  DATA: at cnt==div, shift sample into shift[7] (right-shift, so LSB first), cnt=0, idx++. After idx 7 -> STOP.
  STOP: at cnt==div, sample. If 1 -> data<=shift, valid=1 for one cycle, go to IDLE. If 0 -> frame_err=1 for one cycle, data unchanged, go to WAIT_HIGH.
  WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break condition produces exactly one frame_err.
- Samples fall at bit centres. Latency from the rx falling edge to valid is SYNC_STAGES+1 + half + 9*(div+1) cycles, ±1.
- Back-to-back frames: IDLE is re-entered at the stop-bit centre, so a start bit immediately following the stop bit is caught.
- valid and frame_err are never high together. There is no ack or overrun handling; the consumer must capture data on valid.
- Reset mid-frame aborts at once: no valid is issued, and the next start edge is accepted after reset deasserts.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit decision is the 2-of-3 majority of rx_s at sample cycle t-1, t, t+1. A 3-entry history is kept, and the decision is taken one cycle after the nominal sample point. This applies to the start qualification, data bits and stop bit. Latency grows by 1 cycle.
- Undefined: a single rx_s sample at the nominal point; no history register.

Test Plan:
- Reset, bps=100, send 0x55 with 434-cycle bits -> exactly one valid, data=0x55, frame_err=0. valid lands at 3+216+9*434 cycles ±1 after the falling edge.
- bps=000, send 0xA3, then 0x00 and 0xFF back-to-back with one stop bit each -> three valid pulses with data 0xA3, 0x00, 0xFF; no frame_err.
- 100-cycle low glitch on rx at bps=100 -> no valid, no frame_err; busy high for about 217 cycles, then low.
- Send 0x3C with stop bit held low for 20 bit times -> one frame_err pulse, no valid, data keeps its previous value. Busy stays high until rx returns high, then 0x81 sent next is received correctly.
- Assert rst at bit 4 of a frame -> outputs go to reset values in the same cycle; no valid from the aborted frame. The next frame, 0x7E, is received correctly.
- With UART_RX_MAJORITY_EN: a 1-cycle inverted spike on the centre of every data bit of 0x96 -> data=0x96. Without the macro, the same stimulus yields a corrupted byte.
